// File: rtl/alu_32.sv
// 32-bit ALU with a registered result and zero flag (one-cycle latency).
// Optional multiply on code 1001 is enabled by defining ALU32_MUL_EN.
module alu_32 (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] srca,
   input  logic [31:0] srcb,
   input  logic [3:0]  alucontrol,
   input  logic [4:0]  shamt,
   output logic [31:0] aluout,
   output logic        zero
);

   logic [31:0] w_result;
   logic        w_zero;
   logic [31:0] r_aluout;
   logic        r_zero;

   always_comb begin
      w_result = 32'h0;
      case (alucontrol)
         4'b0000: w_result = srca + srcb;
         4'b1000: w_result = srca - srcb;
         4'b0001: w_result = srca << shamt;
         4'b0010: w_result = {31'h0, $signed(srca) < $signed(srcb)};
         4'b0011: w_result = {31'h0, srca < srcb};
         4'b0100: w_result = srca ^ srcb;
         4'b0101: w_result = srca >> shamt;
         4'b1101: w_result = $unsigned($signed(srca) >>> shamt);
         4'b0110: w_result = srca | srcb;
         4'b0111: w_result = srca & srcb;
`ifdef ALU32_MUL_EN
         // Low half of the product is identical for signed and unsigned operands.
         4'b1001: w_result = srca * srcb;
`endif
         default: w_result = 32'h0;
      endcase
   end

   // Flag comes from the same value being captured, so it can never lag aluout.
   assign w_zero = (w_result == 32'h0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_aluout <= 32'h0;
         r_zero   <= 1'b1;
      end else begin
         r_aluout <= w_result;
         r_zero   <= w_zero;
      end
   end

   assign aluout = r_aluout;
   assign zero   = r_zero;

endmodule

// File: tb/tb_alu_32.sv
// Bench for alu_32: directed vector table, reset sequences and random
// operations checked against an arithmetic reference model.
module tb_alu_32;

   logic        clk;
   logic        reset;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic [3:0]  alucontrol;
   logic [4:0]  shamt;
   logic [31:0] aluout;
   logic        zero;

   int total = 0;
   int bad   = 0;

   alu_32 dut (
      .clk        (clk),
      .reset      (reset),
      .srca       (srca),
      .srcb       (srcb),
      .alucontrol (alucontrol),
      .shamt      (shamt),
      .aluout     (aluout),
      .zero       (zero)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input logic [4:0] sh);
      logic [31:0] fill;
      longint unsigned prod;
      case (op)
         4'b0000: return 32'(a + b);
         4'b1000: return 32'(a - b);
         4'b0001: return 32'(a * (32'd1 << sh));
         // signed compare via offset binary: flip the sign bits, compare unsigned
         4'b0010: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a / (32'd1 << sh);
         4'b1101: begin
            fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
            return (a / (32'd1 << sh)) | fill;
         end
         4'b0110: return a | b;
         4'b0111: return a & b;
`ifdef ALU32_MUL_EN
         4'b1001: begin
            prod = longint'(a) * longint'(b);
            return prod[31:0];
         end
`endif
         default: return 32'h0;
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] exp_out, input logic exp_zero);
      total++;
      if (aluout !== exp_out || zero !== exp_zero) begin
         bad++;
         $display("FAIL %s: got aluout=%h zero=%b expected aluout=%h zero=%b",
                  name, aluout, zero, exp_out, exp_zero);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [4:0] sh);
      @(negedge clk);
      reset      = rst;
      srca       = a;
      srcb       = b;
      alucontrol = op;
      shamt      = sh;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  sh;
      logic [31:0] exp_out;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] ra, rb, e;
      logic [3:0]  rop;
      logic [4:0]  rsh;

      vecs.push_back('{"sub_c_5",     32'hC,         32'h5, 4'b1000, 5'd0,  32'h7,         1'b0});
      vecs.push_back('{"sub_eq",      32'h5,         32'h5, 4'b1000, 5'd0,  32'h0,         1'b1});
      vecs.push_back('{"add_wrap",    32'hFFFF_FFFF, 32'h1, 4'b0000, 5'd0,  32'h0,         1'b1});
      vecs.push_back('{"srl_4",       32'h8000_0000, 32'h0, 4'b0101, 5'd4,  32'h0800_0000, 1'b0});
      vecs.push_back('{"sra_4",       32'h8000_0000, 32'h0, 4'b1101, 5'd4,  32'hF800_0000, 1'b0});
      vecs.push_back('{"sll_31",      32'h1,         32'h0, 4'b0001, 5'd31, 32'h8000_0000, 1'b0});
      vecs.push_back('{"slt_neg",     32'hFFFF_FFFF, 32'h1, 4'b0010, 5'd0,  32'h1,         1'b0});
      vecs.push_back('{"sltu_big",    32'hFFFF_FFFF, 32'h1, 4'b0011, 5'd0,  32'h0,         1'b1});
      vecs.push_back('{"sll_0",       32'hDEAD_BEEF, 32'h0, 4'b0001, 5'd0,  32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{"srl_0",       32'h8765_4321, 32'h3, 4'b0101, 5'd0,  32'h8765_4321, 1'b0});
      vecs.push_back('{"sra_0",       32'h8765_4321, 32'h3, 4'b1101, 5'd0,  32'h8765_4321, 1'b0});
      vecs.push_back('{"xor",         32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 5'd0, 32'h0FF0_0FF0, 1'b0});
      vecs.push_back('{"or",          32'hF0F0_0000, 32'h0000_0F0F, 4'b0110, 5'd0, 32'hF0F0_0F0F, 1'b0});
      vecs.push_back('{"and",         32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0111, 5'd0, 32'hF000_F000, 1'b0});
      vecs.push_back('{"add_ovf",     32'h7FFF_FFFF, 32'h1, 4'b0000, 5'd0,  32'h8000_0000, 1'b0});
      vecs.push_back('{"unused_1010", 32'h1234_5678, 32'h1, 4'b1010, 5'd3,  32'h0,         1'b1});
      vecs.push_back('{"unused_1111", 32'hFFFF_FFFF, 32'hF, 4'b1111, 5'd3,  32'h0,         1'b1});
`ifdef ALU32_MUL_EN
      vecs.push_back('{"mul_6_7",     32'h6,         32'h7, 4'b1001, 5'd0,  32'd42,        1'b0});
`else
      vecs.push_back('{"mul_off",     32'h6,         32'h7, 4'b1001, 5'd0,  32'h0,         1'b1});
`endif

      // reset state
      reset = 1'b1; srca = '0; srcb = '0; alucontrol = '0; shamt = '0;
      drive(1'b1, 32'h1234_5678, 32'h1, 4'b0000, 5'd0);
      check("reset_state", 32'h0, 1'b1);

      // directed table
      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sh);
         check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_zero);
      end

      // reset mid-stream: in-flight op discarded, next op one cycle after release
      drive(1'b0, 32'h10, 32'h20, 4'b0000, 5'd0);
      check("pre_reset_op", 32'h30, 1'b0);
      drive(1'b1, 32'h11, 32'h22, 4'b0000, 5'd0);
      check("mid_reset", 32'h0, 1'b1);
      drive(1'b0, 32'h40, 32'h1, 4'b1000, 5'd0);
      check("post_reset_op", 32'h3F, 1'b0);
      drive(1'b0, 32'h3, 32'h3, 4'b0111, 5'd0);
      check("post_reset_op2", 32'h3, 1'b0);

      // random stream vs reference model
      for (int n = 0; n < 400; n++) begin
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
         if ($urandom_range(0, 9) == 0) ra = 32'h0;
         rop = 4'($urandom_range(0, 15));
         rsh = 5'($urandom_range(0, 31));
         e   = ref_alu(ra, rb, rop, rsh);
         drive(1'b0, ra, rb, rop, rsh);
         check("random", e, e == 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_32.md
ALU_32 -- requirements
Module: alu_32

Interface
- REQ-001 Parameters: none; datapath width fixed at 32 bits.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
- REQ-004 srca  input  32  operand A.
- REQ-005 srcb  input  32  operand B.
- REQ-006 alucontrol  input  4  operation select, encoding {funct7[5], funct3}.
- REQ-007 shamt  input  5  shift amount for all shift ops; upstream drives srcb[4:0] here for register shifts.
- REQ-008 aluout  output  32  registered result.
- REQ-009 zero  output  1  registered flag, 1 when registered result equals 0.

Function
- REQ-010 Combinational result computed from srca, srcb, alucontrol and shamt in the same cycle; registered into aluout/zero on the next rising clk edge (latency exactly 1 cycle, throughput 1 op/cycle).
- REQ-011 0000 ADD: srca + srcb, modulo 2^32, carry discarded.
- REQ-012 1000 SUB: srca - srcb, modulo 2^32, borrow discarded.
- REQ-013 0001 SLL: srca << shamt, zero fill.
- REQ-014 0010 SLT: 32'd1 if signed(srca) < signed(srcb), else 0.
- REQ-015 0011 SLTU: 32'd1 if unsigned(srca) < unsigned(srcb), else 0.
- REQ-016 0100 XOR: srca ^ srcb.
- REQ-017 0101 SRL: srca >> shamt, zero fill.
- REQ-018 1101 SRA: srca >>> shamt, sign bit srca[31] replicated.
- REQ-019 0110 OR: srca | srcb.
- REQ-020 0111 AND: srca & srcb.
- REQ-021 All other codes (1001-1100, 1110, 1111): result 32'h0, except 1001 when ALU32_MUL_EN is defined (REQ-027).
- REQ-022 shamt = 0 on any shift op: result equals srca unchanged.
- REQ-023 zero SHALL be derived from the same result value captured into aluout in that cycle, never from a stale value.
- REQ-024 No overflow/carry output; signed overflow wraps silently.

Reset
- REQ-025 When reset is high at a rising clk edge: aluout <= 32'h0, zero <= 1; inputs ignored that cycle.
- REQ-026 Reset asserted mid-stream discards the in-flight result; first valid result appears one cycle after the first edge with reset low.

Configuration
- REQ-027 Macro ALU32_MUL_EN: when defined, code 1001 = MUL, result = low 32 bits of srca * srcb (unsigned/signed identical for low half), same 1-cycle latency; when undefined, code 1001 yields 32'h0 and no multiplier is synthesized.

Verification
- REQ-028 srca=32'hC, srcb=32'h5, alucontrol=1000 -> next cycle aluout=32'h7, zero=0.
- REQ-029 srca=32'h5, srcb=32'h5, alucontrol=1000 -> aluout=0, zero=1; srca=32'hFFFFFFFF, srcb=1, alucontrol=0000 -> aluout=0, zero=1.
- REQ-030 srca=32'h80000000, shamt=4: 0101 -> 32'h08000000; 1101 -> 32'hF8000000; 0001 with srca=1, shamt=31 -> 32'h80000000.
- REQ-031 srca=32'hFFFFFFFF, srcb=1: 0010 -> 1; 0011 -> 0.
- REQ-032 Reset high for one edge while ops stream -> aluout=0, zero=1 that cycle; following op result appears 1 cycle after reset deasserts.
- REQ-033 alucontrol=1001, srca=6, srcb=7 -> aluout=42 with ALU32_MUL_EN defined, aluout=0 and zero=1 without it.
